// File: rtl/rv32im_bus_arbiter.sv
// Round-robin Wishbone arbiter: N masters onto one shared bus, non-preemptive, one dead cycle between owners.
// Define RV32IM_BUS_ARBITER_TIMEOUT_EN to build in the stalled-transfer watchdog (timeout_o, m_err_o pulse).
module rv32im_bus_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_MASTERS-1:0]        req_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]      m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [XLEN-3:0]               adr_o,
  output logic [XLEN-1:0]               dat_o,
  output logic [3:0]                    sel_o,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic                          we_o,
  input  logic                          ack_i,
  input  logic                          err_i,
  output logic                          timeout_o
);

  localparam int unsigned IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned AW   = XLEN - 2;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state;
  logic [IDXW-1:0]        owner;
  logic [IDXW-1:0]        rr_ptr;
  logic [IDXW-1:0]        pick;
  logic                   pick_found;
  logic [IDXW-1:0]        scan_idx;
  logic [NUM_MASTERS-1:0] grant_q;
  logic                   owned;

  // First requester at or after rr_ptr, wrapping past NUM_MASTERS-1 to 0.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      scan_idx = IDXW'((32'(rr_ptr) + i) % NUM_MASTERS);
      if (!pick_found && req_i[scan_idx]) begin
        pick       = scan_idx;
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      grant_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            owner   <= pick;
            grant_q <= NUM_MASTERS'(1) << pick;
            state   <= OWNED;
          end
        end
        OWNED: begin
          if (!req_i[owner]) begin
            state   <= IDLE;
            grant_q <= '0;
            rr_ptr  <= (owner == IDXW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
          end
        end
      endcase
    end
  end

  assign grant_o = grant_q;

  // Reset gates the bus directly so cyc/stb fall without waiting for a clock.
  assign owned = (state == OWNED) && !reset_i;

  always_comb begin
    adr_o = '0;
    dat_o = '0;
    sel_o = '0;
    cyc_o = 1'b0;
    stb_o = 1'b0;
    we_o  = 1'b0;
    if (owned) begin
      adr_o = m_adr_i[owner*AW +: AW];
      dat_o = m_dat_i[owner*XLEN +: XLEN];
      sel_o = m_sel_i[owner*4 +: 4];
      cyc_o = m_cyc_i[owner];
      stb_o = m_stb_i[owner];
      we_o  = m_we_i[owner];
    end
  end

  assign m_ack_o = grant_q & {NUM_MASTERS{ack_i}};

`ifdef RV32IM_BUS_ARBITER_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       timeout_q;
  logic       stall;
  logic       grant_drop;

  assign stall      = cyc_o & stb_o & ~ack_i & ~err_i;
  assign grant_drop = owned && !req_i[owner];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (grant_drop || !stall) begin
        wd_cnt <= '0;
      end else if (wd_cnt + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
        wd_cnt    <= '0;
        timeout_q <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 8'd1;
      end
    end
  end

  assign timeout_o = timeout_q;
  assign m_err_o   = grant_q & {NUM_MASTERS{err_i | timeout_q}};
`else
  assign timeout_o = 1'b0;
  assign m_err_o   = grant_q & {NUM_MASTERS{err_i}};
`endif

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Directed bench for rv32im_bus_arbiter: latency, rotation, no preemption, routing, async reset, watchdog.
module tb_rv32im_bus_arbiter;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [2:0]    req_i;
  logic [2:0]    grant_o;
  logic [89:0]   m_adr_i;
  logic [95:0]   m_dat_i;
  logic [11:0]   m_sel_i;
  logic [2:0]    m_cyc_i;
  logic [2:0]    m_stb_i;
  logic [2:0]    m_we_i;
  logic [2:0]    m_ack_o;
  logic [2:0]    m_err_o;
  logic [29:0]   adr_o;
  logic [31:0]   dat_o;
  logic [3:0]    sel_o;
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic          ack_i;
  logic          err_i;
  logic          timeout_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [2:0]  exp_g [4];

  rv32im_bus_arbiter #(
    .XLEN           (32),
    .NUM_MASTERS    (3),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (req_i),
    .grant_o   (grant_o),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .sel_o     (sel_o),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .ack_i     (ack_i),
    .err_i     (err_i),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  initial begin
    exp_g   = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset_i = 1'b1;
    req_i   = '0;
    ack_i   = 1'b0;
    err_i   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_adr_i[k*30 +: 30] = 30'h100 + 30'(k);
      m_dat_i[k*32 +: 32] = 32'hA000_0000 + 32'(k);
      m_sel_i[k*4 +: 4]   = 4'(k + 1);
    end
    m_cyc_i = '1;
    m_stb_i = '1;
    m_we_i  = 3'b010;

    tick;
    tick;
    check("rst_grant",   64'(grant_o),   64'(0));
    check("rst_cyc",     64'(cyc_o),     64'(0));
    check("rst_stb",     64'(stb_o),     64'(0));
    check("rst_adr",     64'(adr_o),     64'(0));
    check("rst_timeout", 64'(timeout_o), 64'(0));

    // grant latency and bus mirroring of master 1
    reset_i = 1'b0;
    req_i   = 3'b010;
    #1;
    check("pre_grant", 64'(grant_o), 64'(0));
    tick;
    check("lat_grant", 64'(grant_o), 64'(3'b010));
    check("m1_adr",    64'(adr_o),   64'(30'h101));
    check("m1_dat",    64'(dat_o),   64'(32'hA000_0001));
    check("m1_sel",    64'(sel_o),   64'(4'd2));
    check("m1_we",     64'(we_o),    64'(1));
    check("m1_cyc",    64'(cyc_o),   64'(1));
    check("m1_stb",    64'(stb_o),   64'(1));

    // ack/err routing only to owner
    ack_i = 1'b1;
    #1;
    check("ack_route", 64'(m_ack_o), 64'(3'b010));
    check("ack_noerr", 64'(m_err_o), 64'(0));
    ack_i = 1'b0;
    err_i = 1'b1;
    #1;
    check("err_route", 64'(m_err_o), 64'(3'b010));
    check("err_noack", 64'(m_ack_o), 64'(0));
    err_i = 1'b0;

    // async reset between edges
    #2;
    check("pre_async_cyc", 64'(cyc_o), 64'(1));
    reset_i = 1'b1;
    #1;
    check("async_cyc",   64'(cyc_o),   64'(0));
    check("async_stb",   64'(stb_o),   64'(0));
    check("async_grant", 64'(grant_o), 64'(0));
    req_i = '0;
    tick;
    reset_i = 1'b0;

    // rotation with all requesting, one-cycle drops after 4 beats
    req_i = 3'b111;
    tick;
    for (int r = 0; r < 4; r++) begin
      check($sformatf("rot%0d_grant", r), 64'(grant_o), 64'(exp_g[r]));
      for (int b = 0; b < 3; b++) begin
        tick;
        check($sformatf("rot%0d_hold%0d", r, b), 64'(grant_o), 64'(exp_g[r]));
      end
      if (r < 3) begin
        req_i = 3'b111 & ~exp_g[r];
        tick;
        check($sformatf("rot%0d_dead", r), 64'(grant_o), 64'(0));
        req_i = 3'b111;
        tick;
      end
    end

    // master 0 owns; master 2 waiting must not preempt
    req_i = 3'b101;
    for (int b = 0; b < 3; b++) begin
      tick;
      check($sformatf("nopre%0d", b), 64'(grant_o), 64'(3'b001));
    end
    ack_i = 1'b1;
    #1;
    check("nopre_ack", 64'(m_ack_o), 64'(3'b001));
    ack_i = 1'b0;
    req_i = 3'b100;
    tick;
    check("handoff_dead", 64'(grant_o), 64'(0));
    check("drop_cyc",     64'(cyc_o),   64'(0));
    check("drop_stb",     64'(stb_o),   64'(0));
    tick;
    check("handoff_m2",  64'(grant_o), 64'(3'b100));
    check("m2_adr",      64'(adr_o),   64'(30'h102));
    check("m2_we",       64'(we_o),    64'(0));

    // idle with no requests keeps rr_ptr at 0
    req_i = '0;
    tick;
    tick;
    tick;
    check("idle_grant", 64'(grant_o), 64'(0));
    req_i = 3'b011;
    tick;
    check("idle_rr", 64'(grant_o), 64'(3'b001));

`ifdef RV32IM_BUS_ARBITER_TIMEOUT_EN
    for (int b = 0; b < 3; b++) begin
      tick;
      check($sformatf("wd_quiet%0d", b), 64'(timeout_o), 64'(0));
    end
    tick;
    check("wd_pulse",     64'(timeout_o), 64'(1));
    check("wd_err",       64'(m_err_o),   64'(3'b001));
    tick;
    check("wd_pulse_end", 64'(timeout_o), 64'(0));
    check("wd_err_end",   64'(m_err_o),   64'(0));
`else
    for (int b = 0; b < 5; b++) begin
      tick;
      check($sformatf("no_wd_to%0d", b),  64'(timeout_o), 64'(0));
      check($sformatf("no_wd_err%0d", b), 64'(m_err_o),   64'(0));
    end
`endif

    req_i = '0;
    tick;
    check("end_grant", 64'(grant_o), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32im_bus_arbiter.md
RV32IM_BUS_ARBITER -- requirements
Module: rv32im_bus_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 The block SHALL have parameter NUM_MASTERS, default 3, meaning requester count (2..8).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning watchdog limit (1..255).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_i, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port req_i, input, NUM_MASTERS bits: per-master bus request.
REQ-007 The block SHALL have port grant_o, output, NUM_MASTERS bits: one-hot grant, all-zero when idle.
REQ-008 The block SHALL have ports m_adr_i, m_dat_i and m_sel_i, all inputs, of widths NUM_MASTERS*(XLEN-2), NUM_MASTERS*XLEN and NUM_MASTERS*4; each is a flattened per-master field, master k at slice k.
REQ-009 The block SHALL have ports m_cyc_i, m_stb_i and m_we_i, all inputs, NUM_MASTERS bits each: per-master Wishbone controls.
REQ-010 The block SHALL have ports m_ack_o and m_err_o, outputs, NUM_MASTERS bits each: per-master termination.
REQ-011 The block SHALL have outputs adr_o (XLEN-2 bits), dat_o (XLEN bits), sel_o (4 bits), and cyc_o, stb_o and we_o (1 bit each): the shared bus; read data goes from the slave directly to all masters and is not routed here.
REQ-012 The block SHALL have inputs ack_i and err_i, 1 bit each: slave termination.
REQ-013 The block SHALL have output timeout_o, 1 bit: a one-cycle watchdog pulse.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and OWNED, plus a registered owner index and a round-robin pointer rr_ptr.
REQ-015 In IDLE with req_i nonzero, the block SHALL select the first set req_i bit scanning from rr_ptr upward modulo NUM_MASTERS, and move to OWNED.
REQ-016 grant_o SHALL be driven from the registered owner and SHALL assert exactly one cycle after the winning req_i is sampled in IDLE.
REQ-017 In OWNED, the grant SHALL hold while req_i[owner] stays high, whatever the other requests do; there is no preemption.
REQ-018 In OWNED, when req_i[owner] is sampled low, the block SHALL return to IDLE and set rr_ptr to (owner+1) mod NUM_MASTERS.
REQ-019 grant_o SHALL be zero for at least one dead cycle between owners, even if another request is already pending.
REQ-020 In OWNED, adr_o, dat_o, sel_o, cyc_o, stb_o and we_o SHALL combinationally mirror the owner's slice; in IDLE they SHALL all be 0.
REQ-021 m_ack_o[k] SHALL equal ack_i, and m_err_o[k] SHALL equal err_i, only when grant_o[k] is 1; otherwise both SHALL be 0.
REQ-022 Requests from non-owners SHALL never see ack or err.
REQ-023 cyc_o and stb_o SHALL deassert in the same cycle the grant drops, even if the owner still holds m_cyc_i high.
REQ-024 If req_i is all-zero in IDLE, the block SHALL stay in IDLE and rr_ptr SHALL remain unchanged.
REQ-025 The round-robin search SHALL wrap from index NUM_MASTERS-1 to index 0.

Reset
REQ-026 While reset_i is high, the block SHALL force: state IDLE, owner 0, rr_ptr 0, grant_o 0, timeout_o 0, watchdog count 0, and all bus outputs 0.
REQ-027 An assertion of reset_i mid-transfer SHALL drop cyc_o and stb_o immediately, without waiting for a clock edge.
REQ-028 After reset_i deasserts, the first grant SHALL follow the rule in REQ-015.

Configuration
REQ-029 Macro RV32IM_BUS_ARBITER_TIMEOUT_EN SHALL compile the bus watchdog in or out.
REQ-030 With the macro defined, an 8-bit counter SHALL increment each cycle in which cyc_o, stb_o, ~ack_i and ~err_i are all true, and SHALL clear on ack_i, on err_i, on stb_o low, or on grant change.
REQ-031 With the macro defined, when the count reaches TIMEOUT_CYCLES, the block SHALL pulse m_err_o[owner] and timeout_o for one cycle and clear the counter.
REQ-032 With the macro undefined, the counter SHALL be absent, timeout_o SHALL be tied to 0, and m_err_o SHALL follow REQ-021 only.

Verification
REQ-033 Test reset and grant latency: with req_i=3'b010 after reset, grant_o SHALL be 3'b010 one cycle later, and the bus outputs SHALL mirror master 1.
REQ-034 Test rotation: with req_i=3'b111 held, with each owner dropping its req_i for one cycle after 4 beats, the grant order SHALL be 001, 010, 100, 001, each separated by a one-cycle zero grant.
REQ-035 Test no preemption: master 0 owns the bus and master 2 raises req_i; grant_o SHALL stay 3'b001 until req_i[0] falls.
REQ-036 Test ack routing: master 1 owns the bus and ack_i pulses; m_ack_o SHALL be 3'b010 and never 3'b001 or 3'b100.
REQ-037 Test asynchronous reset mid-transfer: reset_i rises between clock edges while cyc_o=1; cyc_o SHALL be 0 before the next edge, and grant_o SHALL be 0.
REQ-038 Test the watchdog, with the macro defined and TIMEOUT_CYCLES=4: an owner holds stb with no ack; after 4 cycles, m_err_o[owner] and timeout_o SHALL pulse for exactly 1 cycle.
